// File: rtl/score_streamer_if.sv
// Purpose: handshake/bus bundle for score_streamer.
//   in_valid/in_ready/in_data : beat input, LANES scores per beat
//   out_valid/out_data/out_idx/out_last : one score per cycle, no backpressure
//   drop_err : pulse when a beat was offered while in_ready was low
// The slave modport is the streamer side; the master modport is the producer/consumer side.
interface score_streamer_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned LANES  = 2,
  parameter int unsigned IDX_W  = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic [IDX_W-1:0]        out_idx;
  logic                    out_last;
  logic                    drop_err;

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data, out_idx, out_last, drop_err
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data, out_idx, out_last, drop_err
  );
endinterface

// File: rtl/score_streamer.sv
// Purpose: buffers NUM_CLASSES signed scores (LANES per input beat) into ping-pong banks
//   and replays each complete frame as a contiguous one-score-per-cycle burst.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : score_streamer_if.slave (input beats, output score stream, drop_err)
module score_streamer #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned LANES       = 2,
  parameter int unsigned MIN_GAP     = 0
) (
  input  logic            clk,
  input  logic            rst,
  score_streamer_if.slave bus
);
  localparam int unsigned BEATS  = NUM_CLASSES / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned GAP_W  = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  state_t            state_q;
  logic [1:0]        full_q;
  logic              wr_bank_q;
  logic              rd_bank_q;
  logic [BEAT_W-1:0] beat_q;
  logic [IDX_W-1:0]  rd_idx_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [IDX_W-1:0]  out_idx_q;
  logic              out_last_q;
  logic              drop_err_q;

  logic [DATA_W-1:0] mem_q [2][NUM_CLASSES];

  logic              wr_fire;
  logic              wr_last;
  logic              emit_d;
  logic [IDX_W-1:0]  emit_idx_d;
  logic              emit_last;
  logic              gap_done;

  assign bus.in_ready  = ~full_q[wr_bank_q];
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.drop_err  = drop_err_q;

  assign wr_fire   = bus.in_valid & bus.in_ready;
  assign wr_last   = wr_fire && (beat_q == BEAT_W'(BEATS - 1));
  assign gap_done  = (gap_cnt_q == GAP_W'(MIN_GAP));
  assign emit_last = emit_d && (emit_idx_d == IDX_W'(NUM_CLASSES - 1));

  // Which score (if any) goes out at the next edge; GAP behaves as IDLE once the count expires.
  always_comb begin
    emit_d     = 1'b0;
    emit_idx_d = rd_idx_q;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          emit_d     = 1'b1;
          emit_idx_d = '0;
        end
      end
      STREAM: emit_d = 1'b1;
      GAP: begin
        if (gap_done && full_q[rd_bank_q]) begin
          emit_d     = 1'b1;
          emit_idx_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Bank storage: no reset needed, full flags qualify the contents.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int j = 0; j < LANES; j++) begin
        mem_q[wr_bank_q][IDX_W'(int'(beat_q) * LANES + j)] <= bus.in_data[j*DATA_W +: DATA_W];
      end
    end
  end

  // Write-side bookkeeping plus read FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      beat_q      <= '0;
      rd_idx_q    <= '0;
      gap_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      drop_err_q <= bus.in_valid & ~bus.in_ready;

      if (wr_fire) begin
        if (wr_last) begin
          full_q[wr_bank_q] <= 1'b1;
          wr_bank_q         <= ~wr_bank_q;
          beat_q            <= '0;
        end else begin
          beat_q <= beat_q + 1'b1;
        end
      end

      out_valid_q <= emit_d;
      out_last_q  <= emit_last;
      if (emit_d) begin
        out_data_q <= mem_q[rd_bank_q][emit_idx_d];
        out_idx_q  <= emit_idx_d;
        rd_idx_q   <= emit_idx_d + 1'b1;
      end

      // Frame end frees the bank; the write side never completes into the bank being drained.
      if (emit_last) begin
        full_q[rd_bank_q] <= 1'b0;
        rd_bank_q         <= ~rd_bank_q;
        gap_cnt_q         <= '0;
        state_q           <= (MIN_GAP > 0) ? GAP : IDLE;
      end else if (emit_d) begin
        state_q <= STREAM;
      end else if (state_q == GAP) begin
        if (gap_done) state_q <= IDLE;
        else          gap_cnt_q <= gap_cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_score_streamer.sv
// Self-checking bench for score_streamer: scoreboard of expected (idx, data, last) entries
// pushed on beat acceptance, popped as the stream comes out.
module tb_score_streamer;
  typedef struct packed {
    logic [3:0]  idx;
    logic [11:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   beat_no = 0;
  exp_t exp_q[$];

  score_streamer_if #(.DATA_W(12), .LANES(2), .IDX_W(4)) bus0 ();
  score_streamer_if #(.DATA_W(12), .LANES(2), .IDX_W(4)) bus3 ();

  assign bus3.in_valid = bus0.in_valid;
  assign bus3.in_data  = bus0.in_data;

  score_streamer #(.DATA_W(12), .NUM_CLASSES(10), .LANES(2), .MIN_GAP(0)) u_dut (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  score_streamer #(.DATA_W(12), .NUM_CLASSES(10), .LANES(2), .MIN_GAP(3)) u_gap (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_beat(input logic [11:0] s0, input logic [11:0] s1, input bit polite,
                           output int waits);
    bit   acc;
    exp_t e;
    waits = 0;
    if (polite) begin
      for (int w = 0; w < 200 && !bus0.in_ready; w++) begin
        bus0.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus0.in_data  = {s1, s0};
    bus0.in_valid = 1'b1;
    acc = 1'b0;
    for (int w = 0; w < 200 && !acc; w++) begin
      acc = bus0.in_ready;
      if (!acc) waits++;
      @(posedge clk); #1;
    end
    if (!acc) begin
      n_cmp++; n_mis++;
      $display("FAIL beat_accept: in_ready stayed 0 for 200 cycles, required 1");
    end else begin
      for (int j = 0; j < 2; j++) begin
        e.idx  = 4'(beat_no * 2 + j);
        e.data = (j == 0) ? s0 : s1;
        e.last = (beat_no * 2 + j == 9);
        exp_q.push_back(e);
      end
      beat_no = (beat_no == 4) ? 0 : beat_no + 1;
    end
  endtask

  task automatic do_reset();
    bus0.in_valid = 1'b0;
    bus0.in_data  = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    beat_no = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus0.in_valid = 1'b0;
    bus0.in_data  = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus0.out_valid, bus0.out_data, bus0.out_idx, bus0.out_last, bus0.drop_err} !== 19'd0) begin
      n_mis++;
      $display("FAIL reset_outputs: got v=%b d=%h i=%0d l=%b e=%b, required all 0",
               bus0.out_valid, bus0.out_data, bus0.out_idx, bus0.out_last, bus0.drop_err);
    end
    n_cmp++;
    if (bus0.in_ready !== 1'b1) begin
      n_mis++; $display("FAIL reset_in_ready: got %b, required 1", bus0.in_ready);
    end
    rst = 1'b0;
    exp_q.delete();
    beat_no = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus0.out_valid, bus3.out_valid, bus0.drop_err, bus0.in_ready} !== 4'b0001) begin
      n_mis++;
      $display("FAIL post_reset_idle: got v0=%b v3=%b err=%b rdy=%b, required 0 0 0 1",
               bus0.out_valid, bus3.out_valid, bus0.drop_err, bus0.in_ready);
    end
  endtask

  task automatic test_basic();
    int k, first, last, cnt, extra, wt;
    bit done;
    exp_t e, o;
    do_reset();
    first = -1; last = -1; cnt = 0; extra = 0; done = 1'b0; k = 0;
    fork
      begin
        for (int b = 0; b < 5; b++) send_beat(12'(2 * b), 12'(2 * b + 1), 1'b0, wt);
        k = cyc;
        bus0.in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        for (int c = 0; c < 60 && !(done && exp_q.size() == 0); c++) begin
          @(negedge clk);
          if (bus0.out_valid) begin
            if (first < 0) first = cyc;
            last = cyc; cnt++;
            n_cmp++;
            o = '{bus0.out_idx, bus0.out_data, bus0.out_last};
            if (exp_q.size() == 0) begin
              n_mis++; $display("FAIL basic_sb: unexpected score idx=%0d", o.idx);
            end else begin
              e = exp_q.pop_front();
              if (o !== e) begin
                n_mis++;
                $display("FAIL basic_sb: got idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                         o.idx, o.data, o.last, e.idx, e.data, e.last);
              end
            end
          end
        end
      end
    join
    repeat (3) begin
      @(negedge clk);
      if (bus0.out_valid) extra++;
    end
    n_cmp++;
    if (first !== k + 1) begin
      n_mis++; $display("FAIL basic_latency: first valid at edge %0d, required %0d", first, k + 1);
    end
    n_cmp++;
    if (cnt !== 10 || last - first !== 9) begin
      n_mis++; $display("FAIL basic_burst: got %0d valid over span %0d, required 10 over 9", cnt, last - first);
    end
    n_cmp++;
    if (extra !== 0 || exp_q.size() !== 0) begin
      n_mis++; $display("FAIL basic_tail: extra=%0d pending=%0d, required 0 0", extra, exp_q.size());
    end
  endtask

  task automatic test_signed();
    int sc[10];
    int best_val, best_idx, wt;
    bit done;
    exp_t e, o;
    sc = '{-2048, 2047, -1, 0, 1, -2, 100, -100, -2048, 2046};
    do_reset();
    best_val = -100000; best_idx = -1; done = 1'b0;
    fork
      begin
        for (int b = 0; b < 5; b++) send_beat(12'(sc[2 * b]), 12'(sc[2 * b + 1]), 1'b0, wt);
        bus0.in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        for (int c = 0; c < 60 && !(done && exp_q.size() == 0); c++) begin
          @(negedge clk);
          if (bus0.out_valid) begin
            if (int'($signed(bus0.out_data)) > best_val) begin
              best_val = int'($signed(bus0.out_data));
              best_idx = int'(bus0.out_idx);
            end
            n_cmp++;
            o = '{bus0.out_idx, bus0.out_data, bus0.out_last};
            if (exp_q.size() == 0) begin
              n_mis++; $display("FAIL signed_sb: unexpected score idx=%0d", o.idx);
            end else begin
              e = exp_q.pop_front();
              if (o !== e) begin
                n_mis++;
                $display("FAIL signed_sb: got idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                         o.idx, o.data, o.last, e.idx, e.data, e.last);
              end
            end
          end
        end
      end
    join
    n_cmp++;
    if (best_idx !== 1 || best_val !== 2047) begin
      n_mis++; $display("FAIL signed_argmax: got idx=%0d val=%0d, required idx=1 val=2047", best_idx, best_val);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_mis++; $display("FAIL signed_drain: %0d scores pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int f0, l0, c0, c3, f3, l3, last3, f3b, wt;
    logic [11:0] d3b;
    exp_t e, o;
    do_reset();
    f0 = -1; l0 = -1; c0 = 0; c3 = 0; f3 = -1; l3 = -1; last3 = -1; f3b = -1; d3b = '0;
    fork
      begin
        for (int b = 0; b < 10; b++) send_beat(12'(2 * b), 12'(2 * b + 1), 1'b0, wt);
        bus0.in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          if (bus0.out_valid) begin
            if (f0 < 0) f0 = cyc;
            l0 = cyc; c0++;
            n_cmp++;
            o = '{bus0.out_idx, bus0.out_data, bus0.out_last};
            if (exp_q.size() == 0) begin
              n_mis++; $display("FAIL b2b_sb: unexpected score idx=%0d", o.idx);
            end else begin
              e = exp_q.pop_front();
              if (o !== e) begin
                n_mis++;
                $display("FAIL b2b_sb: got idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                         o.idx, o.data, o.last, e.idx, e.data, e.last);
              end
            end
          end
          if (bus3.out_valid) begin
            if (f3 < 0) f3 = cyc;
            l3 = cyc; c3++;
            if (bus3.out_last && last3 < 0) last3 = cyc;
            else if (last3 >= 0 && f3b < 0 && bus3.out_idx == 4'd0) begin
              f3b = cyc; d3b = bus3.out_data;
            end
          end
        end
      end
    join
    n_cmp++;
    if (c0 !== 20 || l0 - f0 !== 19) begin
      n_mis++; $display("FAIL b2b_contiguous: got %0d valid over span %0d, required 20 over 19", c0, l0 - f0);
    end
    n_cmp++;
    if (c3 !== 20 || l3 - f3 !== 22) begin
      n_mis++; $display("FAIL gap_total: got %0d valid over span %0d, required 20 over 22", c3, l3 - f3);
    end
    n_cmp++;
    if (f3b - last3 - 1 !== 3) begin
      n_mis++; $display("FAIL gap_idle: got %0d idle cycles, required 3", f3b - last3 - 1);
    end
    n_cmp++;
    if (d3b !== 12'd10) begin
      n_mis++; $display("FAIL gap_data: second frame idx0 got %h, required 00a", d3b);
    end
  endtask

  task automatic test_overflow();
    int total_waits, first_stall, drops, wt;
    bit done;
    exp_t e, o;
    do_reset();
    total_waits = 0; first_stall = -1; drops = 0; done = 1'b0;
    fork
      begin
        for (int b = 0; b < 15; b++) begin
          send_beat(12'(100 + 2 * b), 12'(101 + 2 * b), 1'b0, wt);
          if (wt > 0 && first_stall < 0) first_stall = b;
          total_waits += wt;
        end
        bus0.in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        for (int c = 0; c < 100 && !(done && exp_q.size() == 0); c++) begin
          @(negedge clk);
          if (bus0.drop_err) drops++;
          if (bus0.out_valid) begin
            n_cmp++;
            o = '{bus0.out_idx, bus0.out_data, bus0.out_last};
            if (exp_q.size() == 0) begin
              n_mis++; $display("FAIL ovf_sb: unexpected score idx=%0d", o.idx);
            end else begin
              e = exp_q.pop_front();
              if (o !== e) begin
                n_mis++;
                $display("FAIL ovf_sb: got idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                         o.idx, o.data, o.last, e.idx, e.data, e.last);
              end
            end
          end
        end
      end
    join
    n_cmp++;
    if (first_stall !== 10) begin
      n_mis++; $display("FAIL ovf_first_stall: first stalled beat %0d, required 10", first_stall);
    end
    n_cmp++;
    if (total_waits !== 5) begin
      n_mis++; $display("FAIL ovf_stall_cycles: got %0d, required 5", total_waits);
    end
    n_cmp++;
    if (drops !== 5) begin
      n_mis++; $display("FAIL ovf_drop_err: got %0d pulses, required 5", drops);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_mis++; $display("FAIL ovf_drain: %0d scores pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int quiet, cnt, wt;
    bit found, done;
    exp_t e, o;
    do_reset();
    found = 1'b0; quiet = 0; cnt = 0;
    fork
      begin
        for (int b = 0; b < 10; b++) send_beat(12'(200 + 2 * b), 12'(201 + 2 * b), 1'b0, wt);
        bus0.in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && !found; c++) begin
          @(negedge clk);
          if (bus0.out_valid) begin
            n_cmp++;
            o = '{bus0.out_idx, bus0.out_data, bus0.out_last};
            e = exp_q.pop_front();
            if (o !== e) begin
              n_mis++;
              $display("FAIL rstmid_sb: got idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                       o.idx, o.data, o.last, e.idx, e.data, e.last);
            end
            if (bus0.out_idx == 4'd4) found = 1'b1;
          end
        end
      end
    join
    n_cmp++;
    if (!found) begin
      n_mis++; $display("FAIL rstmid_reach: out_idx 4 not seen, required within 40 cycles");
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus0.out_valid !== 1'b0) begin
      n_mis++; $display("FAIL rstmid_async: out_valid=%b after reset, required 0", bus0.out_valid);
    end
    exp_q.delete();
    beat_no = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus0.out_valid) quiet++;
    end
    n_cmp++;
    if (quiet !== 0) begin
      n_mis++; $display("FAIL rstmid_quiet: %0d valid cycles after reset, required 0", quiet);
    end
    @(posedge clk); #1;
    done = 1'b0;
    fork
      begin
        for (int b = 0; b < 5; b++) send_beat(12'(700 + 2 * b), 12'(701 + 2 * b), 1'b0, wt);
        bus0.in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        for (int c = 0; c < 60 && !(done && exp_q.size() == 0); c++) begin
          @(negedge clk);
          if (bus0.out_valid) begin
            cnt++;
            n_cmp++;
            o = '{bus0.out_idx, bus0.out_data, bus0.out_last};
            if (exp_q.size() == 0) begin
              n_mis++; $display("FAIL rstmid_new_sb: unexpected score idx=%0d", o.idx);
            end else begin
              e = exp_q.pop_front();
              if (o !== e) begin
                n_mis++;
                $display("FAIL rstmid_new_sb: got idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                         o.idx, o.data, o.last, e.idx, e.data, e.last);
              end
            end
          end
        end
      end
    join
    n_cmp++;
    if (cnt !== 10 || exp_q.size() !== 0) begin
      n_mis++; $display("FAIL rstmid_new_frame: got %0d scores, pending %0d, required 10 and 0", cnt, exp_q.size());
    end
  endtask

  task automatic test_random();
    int drops, cnt, wt;
    bit done;
    exp_t e, o;
    do_reset();
    drops = 0; cnt = 0; done = 1'b0;
    fork
      begin
        for (int b = 0; b < 250; b++) begin
          for (int g = 0; g < 20 && $urandom_range(0, 99) >= 30; g++) begin
            bus0.in_valid = 1'b0;
            @(posedge clk); #1;
          end
          send_beat(12'($urandom), 12'($urandom), 1'b1, wt);
          bus0.in_valid = 1'b0;
        end
        done = 1'b1;
      end
      begin
        for (int c = 0; c < 8000 && !(done && exp_q.size() == 0); c++) begin
          @(negedge clk);
          if (bus0.drop_err) drops++;
          if (bus0.out_valid) begin
            cnt++;
            n_cmp++;
            o = '{bus0.out_idx, bus0.out_data, bus0.out_last};
            if (exp_q.size() == 0) begin
              n_mis++; $display("FAIL rand_sb: unexpected score idx=%0d", o.idx);
            end else begin
              e = exp_q.pop_front();
              if (o !== e) begin
                n_mis++;
                $display("FAIL rand_sb: got idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                         o.idx, o.data, o.last, e.idx, e.data, e.last);
              end
            end
          end
        end
      end
    join
    n_cmp++;
    if (drops !== 0) begin
      n_mis++; $display("FAIL rand_drop_err: got %0d pulses, required 0", drops);
    end
    n_cmp++;
    if (cnt !== 500 || exp_q.size() !== 0) begin
      n_mis++; $display("FAIL rand_count: got %0d scores, pending %0d, required 500 and 0", cnt, exp_q.size());
    end
  endtask

  initial begin
    bus0.in_valid = 1'b0;
    bus0.in_data  = '0;
    test_reset();
    test_basic();
    test_signed();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
